mdu_seq: RTL

- Multi-cycle multiply/divide sequencer sitting beside the EXE stage.
- Replaces the single-cycle combinational multiplier and divider with a radix-2 iterative engine: shift-add for multiply, restoring for divide.
- Owns the architectural HI/LO registers.
- Stalls the pipeline while an operation is in flight, and is flushable on exception or branch squash.

---
 rtl/mdu_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: radix-2 iterative multiply/divide sequencer owning HI/LO.
// Shift-add multiply and restoring divide over magnitudes, with a single
// sign-fix cycle. Divide by zero skips straight to writeback.
//
//   state | meaning
//   IDLE  | waiting for start_i; HI/LO hold last result
//   CALC  | one radix-2 iteration per cycle, WIDTH cycles
//   FIX   | apply result signs for MULT/DIV
//   DONE  | done_o pulse; HI/LO written on this edge
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

    state_t               r_state, w_next;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_sa, r_sb;
    logic [WIDTH-1:0]     r_opd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   r_acc;      // {acc/rem, multiplier/quotient}
    logic [WIDTH-1:0]     r_hi, r_lo;

    logic                 w_accept, w_div, w_sgn, w_divz;
    logic [WIDTH-1:0]     w_a_abs, w_b_abs;
    logic [WIDTH-1:0]     w_acc_hi, w_acc_lo;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_fix;

    assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
    assign w_div    = op_i[1];
    assign w_sgn    = op_i[0];
    assign w_divz   = w_div && (b_i == '0);
    // Unary minus of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_a_abs  = (w_sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_abs  = (w_sgn && b_i[WIDTH-1]) ? -b_i : b_i;

    assign w_acc_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_acc_lo = r_acc[WIDTH-1:0];

    // Multiply step: conditional add into the high half, then shift right.
    assign w_mul_sum  = {1'b0, w_acc_hi} + (w_acc_lo[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, w_acc_lo[WIDTH-1:1]};

    // Divide step: remainder after shift is below 2*divisor, so WIDTH+1 bits
    // hold both the shifted remainder and the trial; bit WIDTH is its sign.
    assign w_rem_sh   = {w_acc_hi, w_acc_lo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_opd};
    assign w_div_next = w_trial[WIDTH]
                      ? {w_rem_sh[WIDTH-1:0], w_acc_lo[WIDTH-2:0], 1'b0}
                      : {w_trial[WIDTH-1:0],  w_acc_lo[WIDTH-2:0], 1'b1};

    // Sign correction; sign flags are only set for signed ops.
    always_comb begin
        w_fix = r_acc;
        if (!r_is_div) begin
            if (r_sa ^ r_sb) w_fix = -r_acc;
        end else begin
            if (r_sa ^ r_sb) w_fix[WIDTH-1:0]       = -w_acc_lo;
            if (r_sa)        w_fix[2*WIDTH-1:WIDTH] = -w_acc_hi;
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Next-state logic; flush returns to IDLE from any active state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_divz ? S_DONE : S_CALC;
            S_CALC: if (flush_i)  w_next = S_IDLE;
                    else if (r_cnt == CNT_ONE) w_next = S_FIX;
            S_FIX:  w_next = flush_i ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: stall until the instruction may retire in DONE.
    always_comb begin
        stall_o = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
        done_o  = (r_state == S_DONE) && !flush_i;
    end

    // Datapath: operand capture, iteration, sign fix and HI/LO writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_is_div <= w_div;
                    r_sa     <= w_sgn && a_i[WIDTH-1];
                    r_sb     <= w_sgn && b_i[WIDTH-1];
                    r_cnt    <= CNT_INIT;
                    r_opd    <= w_div ? w_b_abs : w_a_abs;
                    if (w_divz)
                        r_acc <= {a_i, {WIDTH{1'b1}}};
                    else
                        r_acc <= {{WIDTH{1'b0}}, (w_div ? w_a_abs : w_b_abs)};
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                S_FIX:  r_acc <= w_fix;
                S_DONE: if (!flush_i) begin
                    r_hi <= w_acc_hi;
                    r_lo <= w_acc_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;

endmodule
